// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter component library.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} ovf_mode_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_updown_counter_en_prescaler.sv
// Enable prescaler: tick on every PRESCALE-th en cycle; restart returns it to 0.
// Latency: tick is combinational from en and the registered phase.
module en_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int W = clog2_min1(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] phase;

  assign tick = en && (phase == LAST);

  // With PRESCALE=1 LAST is 0, so phase never leaves 0 and tick == en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + W'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulus counter with load, clear, wrap/saturate and enable prescaler; 1 clk latency.
// Optional sticky overflow flag (ovf/ovf_clr) under MOD_COUNTER_STICKY_OVF_EN.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            up_dn,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic [SIZE-1:0] max_val,
  input  logic            sat_mode,
  output logic [SIZE-1:0] cur_count,
  output logic            tc,
  output logic            wrap
`ifdef MOD_COUNTER_STICKY_OVF_EN
  ,
  input  logic            ovf_clr,
  output logic            ovf
`endif
);

  dir_e            dir;
  ovf_mode_e       mode;
  logic            tick;
  logic [SIZE-1:0] step_val;
  logic            step_wrap;
  logic            step_over;

  assign dir  = dir_e'(up_dn);
  assign mode = ovf_mode_e'(sat_mode);
  assign tc   = (dir == DIR_UP) ? (cur_count == max_val) : (cur_count == '0);

  en_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clr | load),
    .tick    (tick)
  );

  // step_over marks a step refused at a boundary in saturate mode.
  always_comb begin
    step_val  = cur_count;
    step_wrap = 1'b0;
    step_over = 1'b0;
    if (dir == DIR_UP) begin
      if (cur_count < max_val) begin
        step_val = cur_count + SIZE'(1);
      end else if (mode == MODE_SAT) begin
        step_val  = max_val;
        step_over = 1'b1;
      end else begin
        step_val  = '0;
        step_wrap = 1'b1;
      end
    end else begin
      if (cur_count > max_val) begin
        step_val = max_val;
      end else if (cur_count != '0) begin
        step_val = cur_count - SIZE'(1);
      end else if (mode == MODE_SAT) begin
        step_over = 1'b1;
      end else begin
        step_val  = max_val;
        step_wrap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_count <= '0;
      wrap      <= 1'b0;
    end else if (clr) begin
      cur_count <= '0;
      wrap      <= 1'b0;
    end else if (load) begin
      cur_count <= (load_val > max_val) ? max_val : load_val;
      wrap      <= 1'b0;
    end else if (tick) begin
      cur_count <= step_val;
      wrap      <= step_wrap;
    end else begin
      wrap      <= 1'b0;
    end
  end

`ifdef MOD_COUNTER_STICKY_OVF_EN
  // A set on the same edge as ovf_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (!clr && !load && tick && (step_wrap || step_over)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
